riscv_if_parcel_fifo: RTL and testbench



---
 rtl/riscv_if_parcel_fifo.sv | 119 +++++++++++
 tb/tb_riscv_if_parcel_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/riscv_if_parcel_fifo.sv
// First-word-fall-through parcel buffer between I-cache and decode; optional same-cycle bypass via RISCV_IF_PARCEL_BYPASS_EN.
// Latency: one cycle from push to id_* outputs (zero with bypass on an empty buffer).
// Backpressure: registered if_stall leaves SKID slots for in-flight parcels; id_stall holds the head entry.
module riscv_if_parcel_fifo #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4,
  parameter int SKID        = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [XLEN-1:0]            if_parcel_pc,
  input  logic [PARCEL_SIZE-1:0]     if_parcel,
  input  logic                       if_parcel_valid,
  input  logic                       if_parcel_misaligned,
  output logic                       if_stall,
  input  logic                       if_flush,
  output logic [XLEN-1:0]            id_pc,
  output logic [PARCEL_SIZE-1:0]     id_parcel,
  output logic                       id_parcel_valid,
  output logic                       id_parcel_misaligned,
  input  logic                       id_stall,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PARCEL_SIZE-1:0] parcel;
    logic                   misaligned;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            stall_q, stall_d;

  logic            empty, full, push, pop, byp_take;
  entry_t          in_ent, head;

  always_comb begin
    in_ent.pc         = if_parcel_pc;
    in_ent.parcel     = if_parcel;
    in_ent.misaligned = if_parcel_misaligned;

    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    head     = empty ? '0 : mem_q[rd_ptr_q];
    byp_take = 1'b0;

`ifdef RISCV_IF_PARCEL_BYPASS_EN
    // Empty buffer: present the incoming parcel directly; only store it if decode stalls.
    if (empty && if_parcel_valid && !if_flush) begin
      head     = in_ent;
      byp_take = !id_stall;
    end
    id_parcel_valid = (!empty || if_parcel_valid) && !if_flush;
`else
    id_parcel_valid = !empty && !if_flush;
`endif

    push = if_parcel_valid && !if_flush && !full && !byp_take;
    pop  = !empty && !id_stall && !if_flush;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_ent;
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (if_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A parcel arriving at a full buffer is dropped and latched as a sticky error.
    overflow_d = overflow_q | (if_parcel_valid & ~if_flush & full);
    stall_d    = (count_d >= CW'(DEPTH - SKID));
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
    end
  end

  assign id_pc                = head.pc;
  assign id_parcel            = head.parcel;
  assign id_parcel_misaligned = head.misaligned;
  assign fifo_count           = count_q;
  assign overflow             = overflow_q;
  assign if_stall             = stall_q;

endmodule

// File: tb/tb_riscv_if_parcel_fifo.sv
// Bench for riscv_if_parcel_fifo: directed scenarios then random traffic, checked against a queue-based model.
module tb_riscv_if_parcel_fifo;
  localparam int DEPTH = 4;
  localparam int SKID  = 2;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] if_parcel_pc = '0;
  logic [31:0] if_parcel = '0;
  logic        if_parcel_valid = 1'b0;
  logic        if_parcel_misaligned = 1'b0;
  logic        if_stall;
  logic        if_flush = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_parcel;
  logic        id_parcel_valid;
  logic        id_parcel_misaligned;
  logic        id_stall = 1'b0;
  logic [2:0]  fifo_count;
  logic        overflow;

  riscv_if_parcel_fifo #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .if_parcel_pc(if_parcel_pc), .if_parcel(if_parcel), .if_parcel_valid(if_parcel_valid),
    .if_parcel_misaligned(if_parcel_misaligned), .if_stall(if_stall), .if_flush(if_flush),
    .id_pc(id_pc), .id_parcel(id_parcel), .id_parcel_valid(id_parcel_valid),
    .id_parcel_misaligned(id_parcel_misaligned), .id_stall(id_stall),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] parcel;
    logic        mis;
  } ent_t;

  ent_t mq[$];
  logic m_ovf   = 1'b0;
  logic m_stall = 1'b0;
  int   total   = 0;
  int   passed  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_stall = 1'b0;
  endtask

  // One cycle: drive inputs, check outputs mid-cycle against the model, advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] par,
                      input logic mis, input logic fl, input logic st);
    logic        ev, emis, chk_data, byp;
    logic [31:0] epc, epar;
    int          sz;
    ent_t        e;
    if_parcel_valid = v; if_parcel_pc = pc; if_parcel = par;
    if_parcel_misaligned = mis; if_flush = fl; id_stall = st;
    #1;
    sz = mq.size();
    byp = 1'b0;
    if (sz != 0) begin
      ev = !fl; epc = mq[0].pc; epar = mq[0].parcel; emis = mq[0].mis; chk_data = !fl;
    end else begin
      ev = 1'b0; epc = '0; epar = '0; emis = 1'b0; chk_data = 1'b1;
    end
`ifdef RISCV_IF_PARCEL_BYPASS_EN
    if (sz == 0 && v && !fl) begin
      byp = 1'b1; ev = 1'b1; epc = pc; epar = par; emis = mis; chk_data = 1'b1;
    end
`endif
    chk("id_parcel_valid", 32'(id_parcel_valid), 32'(ev));
    if (chk_data) begin
      chk("id_pc", id_pc, epc);
      chk("id_parcel", id_parcel, epar);
      chk("id_misaligned", 32'(id_parcel_misaligned), 32'(emis));
    end
    chk("fifo_count", 32'(fifo_count), 32'(sz));
    chk("if_stall", 32'(if_stall), 32'(m_stall));
    chk("overflow", 32'(overflow), 32'(m_ovf));

    if (fl) begin
      mq.delete();
    end else begin
      if (sz != 0 && !st) void'(mq.pop_front());
      if (v) begin
        if (sz == DEPTH) begin
          m_ovf = 1'b1;
        end else if (!(byp && !st)) begin
          e.pc = pc; e.parcel = par; e.mis = mis;
          mq.push_back(e);
        end
      end
    end
    m_stall = (mq.size() >= DEPTH - SKID);
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, st);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(id_parcel_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_stall", 32'(if_stall), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    #11 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // Streaming with no decode stall.
    step(1'b1, 32'h100, 32'hA0000001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hA0000002, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h108, 32'hA0000003, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Fill under decode stall, then overflow with a fifth parcel, then drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h200 + 32'(4 * i), 32'hB0000000 + 32'(i), i[0], 1'b0, 1'b1);
    step(1'b1, 32'h210, 32'hB0000010, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(6, 1'b0);

    // Flush with a parcel arriving in the same cycle.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h280 + 32'(4 * i), 32'hC0000000 + 32'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h300, 32'hC0000300, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b0);

    // Asynchronous reset between edges.
    step(1'b1, 32'h380, 32'hD0000000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h384, 32'hD0000001, 1'b0, 1'b0, 1'b1);
    if_parcel_valid = 1'b0;
    #3 ARESETn = 1'b0;
    #1;
    chk("arst_valid", 32'(id_parcel_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_stall", 32'(if_stall), 32'd0);
    model_reset();
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // Bypass path on an empty buffer (zero-latency only when the macro is set).
    step(1'b1, 32'h400, 32'hE0000000, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
    idle(8, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
